// File: rtl/cla_accum_pkg.sv
// Shared types and helpers for the lane accumulator and its CLA group cells.
// Default geometry: 32-bit data, 4-bit lookahead groups, 4 lanes.
package cla_accum_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;
  localparam int CLA_LANES = 4;

  localparam int NGROUPS = CLA_WIDTH / CLA_GROUP;
  localparam int LANE_W  = $clog2(CLA_LANES);

  typedef logic [LANE_W-1:0] lane_t;

  // Group generate / propagate pair produced by one lookahead cell.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Sticky signed-overflow update: overflow happens when both operands share
  // a sign and the result's sign differs from it.
  function automatic logic sat_ovf(input logic ovf_in, input logic acc_sign,
                                   input logic data_sign, input logic sum_sign);
    return ovf_in | ((acc_sign == data_sign) && (sum_sign != acc_sign));
  endfunction

endpackage

// File: rtl/cla_lane_accumulator_group.sv
// cla_group: GROUP-bit carry-lookahead cell. Every internal carry is formed
// directly from bit generate/propagate terms and cin; the cell also exports
// its group generate/propagate so the next level can resolve group carries.
module cla_group
  import cla_accum_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output gp_t              gp
);

  logic [GROUP-1:0] bit_g;
  logic [GROUP-1:0] bit_p;
  logic [GROUP-1:0] bit_c;

  // Carry into bit i = OR over j<i of g[j]&p[j+1..i-1], plus cin&p[0..i-1].
  function automatic logic [GROUP-1:0] bit_carries(input logic [GROUP-1:0] g_in,
                                                   input logic [GROUP-1:0] p_in,
                                                   input logic c_in);
    logic [GROUP-1:0] c_out;
    logic             term;
    c_out = '0;
    for (int i = 0; i < GROUP; i++) begin
      term = c_in;
      for (int j = 0; j < i; j++) term = term & p_in[j];
      c_out[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g_in[j];
        for (int k = j + 1; k < i; k++) term = term & p_in[k];
        c_out[i] = c_out[i] | term;
      end
    end
    return c_out;
  endfunction

  // Group generate: some bit generates and every higher bit propagates it.
  function automatic logic group_gen(input logic [GROUP-1:0] g_in,
                                     input logic [GROUP-1:0] p_in);
    logic res;
    logic term;
    res = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = g_in[j];
      for (int k = j + 1; k < GROUP; k++) term = term & p_in[k];
      res = res | term;
    end
    return res;
  endfunction

  assign bit_g = a & b;
  assign bit_p = a ^ b;
  assign bit_c = bit_carries(bit_g, bit_p, cin);
  assign sum   = bit_p ^ bit_c;
  assign gp.g  = group_gen(bit_g, bit_p);
  assign gp.p  = &bit_p;

endmodule

// File: rtl/cla_lane_accumulator.sv
// cla_lane_accumulator: two-stage multi-lane accumulator with a CLA adder.
// S1 holds lane/clear/operand and the (forwarded) accumulator read; the group
// cells and group-carry resolution sit between S1 and the S2 output register,
// which also writes the lane accumulator back.
// Optional build macro: CLA_ACCUM_OPERAND_ISOLATION_EN (S1 data loads only on
// valid beats and out_sum/out_lane/out_ovf read 0 while out_valid is low).
module cla_lane_accumulator
  import cla_accum_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP,
  parameter int LANES = CLA_LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(LANES)-1:0] in_lane,
  input  logic                     in_clear,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_ovf
);

  localparam int N_GRP = WIDTH / GROUP;
  localparam int LW    = $clog2(LANES);

  // Carry into group k, resolved from group generate/propagate terms only.
  function automatic logic [N_GRP-1:0] group_carries(input logic [N_GRP-1:0] g_in,
                                                     input logic [N_GRP-1:0] p_in,
                                                     input logic c_in);
    logic [N_GRP-1:0] c_out;
    logic             term;
    c_out = '0;
    for (int i = 0; i < N_GRP; i++) begin
      term = c_in;
      for (int j = 0; j < i; j++) term = term & p_in[j];
      c_out[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g_in[j];
        for (int k = j + 1; k < i; k++) term = term & p_in[k];
        c_out[i] = c_out[i] | term;
      end
    end
    return c_out;
  endfunction

  // Handshake
  logic advance;
  logic accept;
  logic s1_en;
  logic out_en;

  // S1 stage
  logic             s1_valid;
  logic [LW-1:0]    s1_lane;
  logic             s1_clear;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s1_acc;
  logic             s1_ovf;

  // S2 / output stage
  logic             out_valid_q;
  logic [LW-1:0]    out_lane_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_ovf_q;

  // Lane state
  logic [WIDTH-1:0] acc_mem [LANES];
  logic [LANES-1:0] ovf_mem;

  // Adder datapath
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;
  gp_t              grp_gp [N_GRP];
  logic [N_GRP-1:0] grp_g;
  logic [N_GRP-1:0] grp_p;
  logic [N_GRP-1:0] grp_cin;

  // Forwarded read
  logic [WIDTH-1:0] acc_rd;
  logic             ovf_rd;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !rst;
  assign accept   = in_valid && in_ready;
  assign out_en   = advance && s1_valid;

`ifdef CLA_ACCUM_OPERAND_ISOLATION_EN
  assign s1_en     = accept;
  assign out_lane  = out_valid_q ? out_lane_q : '0;
  assign out_sum   = out_valid_q ? out_sum_q : '0;
  assign out_ovf   = out_valid_q ? out_ovf_q : 1'b0;
`else
  assign s1_en     = advance;
  assign out_lane  = out_lane_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
`endif
  assign out_valid = out_valid_q;

  // A clear feeds zero as the accumulator operand so the adder passes in_data.
  assign op_a = s1_clear ? '0 : s1_acc;

  for (genvar k = 0; k < N_GRP; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (op_a[k*GROUP +: GROUP]),
      .b   (s1_data[k*GROUP +: GROUP]),
      .cin (grp_cin[k]),
      .sum (sum_next[k*GROUP +: GROUP]),
      .gp  (grp_gp[k])
    );
    assign grp_g[k] = grp_gp[k].g;
    assign grp_p[k] = grp_gp[k].p;
  end

  assign grp_cin  = group_carries(grp_g, grp_p, 1'b0);
  assign ovf_next = s1_clear ? 1'b0
                  : sat_ovf(s1_ovf, s1_acc[WIDTH-1], s1_data[WIDTH-1], sum_next[WIDTH-1]);

  // Accumulator read for the incoming beat, bypassing the result S1 is about
  // to write back when both target the same lane.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_rd = acc_mem[in_lane];
    ovf_rd = ovf_mem[in_lane];
    if (s1_valid && (s1_lane == in_lane)) begin
      acc_rd = sum_next;
      ovf_rd = ovf_next;
    end
  end

  // Stage valid bits: move on every advance, cleared by reset to drop in-flight beats.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid    <= accept;
      out_valid_q <= s1_valid;
    end
  end

  // Stage data registers: S1 captures the beat, S2 captures the finished result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_lane    <= '0;
      s1_clear   <= 1'b0;
      s1_data    <= '0;
      s1_acc     <= '0;
      s1_ovf     <= 1'b0;
      out_lane_q <= '0;
      out_sum_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_lane  <= in_lane;
        s1_clear <= in_clear;
        s1_data  <= in_data;
        s1_acc   <= acc_rd;
        s1_ovf   <= ovf_rd;
      end
      if (out_en) begin
        out_lane_q <= s1_lane;
        out_sum_q  <= sum_next;
        out_ovf_q  <= ovf_next;
      end
    end
  end

  // Lane accumulators and sticky overflow bits, written as a beat leaves S1.
  // NOTE: the lane memory is built from flops and must read 0 after reset, so it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) acc_mem[i] <= '0;
      ovf_mem <= '0;
    end else if (out_en) begin
      acc_mem[s1_lane] <= sum_next;
      ovf_mem[s1_lane] <= ovf_next;
    end
  end

endmodule

// File: tb/tb_cla_lane_accumulator.sv
// Self-checking bench for cla_lane_accumulator (default 32/4/4 geometry).
// A per-lane integer model predicts every consumed result; directed tasks
// add hand-computed literal expectations. Inputs change 1 time unit after a
// rising edge; the monitor samples on the falling edge.
module tb_cla_lane_accumulator;
  import cla_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  lane_t       in_lane;
  logic        in_clear;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  lane_t       out_lane;
  logic [31:0] out_sum;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  cla_lane_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lane   (in_lane),
    .in_clear  (in_clear),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model and compare process ----------------
  typedef struct {
    lane_t       lane;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e_cur;
  longint            model_acc [CLA_LANES];
  bit                model_ovf [CLA_LANES];
  longint            m_a, m_d, m_s;
  logic signed [31:0] m_wrap;
  bit                stalled = 0;
  logic [31:0]       hold_sum;
  lane_t             hold_lane;
  logic              hold_ovf;

  localparam longint MAX_POS = 64'sd2147483647;
  localparam longint MIN_NEG = -64'sd2147483648;

  initial begin
    foreach (model_acc[i]) begin
      model_acc[i] = 0;
      model_ovf[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      foreach (model_acc[i]) begin
        model_acc[i] = 0;
        model_ovf[i] = 0;
      end
      exp_q.delete();
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_hold_sum", out_sum, hold_sum);
        check("stall_hold_lane", out_lane, hold_lane);
        check("stall_hold_ovf", out_ovf, hold_ovf);
        check("stall_hold_valid", out_valid, 1'b1);
      end
`ifdef CLA_ACCUM_OPERAND_ISOLATION_EN
      if (!out_valid) begin
        check("idle_sum_zero", out_sum, 0);
        check("idle_lane_zero", out_lane, 0);
        check("idle_ovf_zero", out_ovf, 0);
      end
`endif
      if (out_valid && out_ready) begin
        check("output_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e_cur = exp_q.pop_front();
          check("model_lane", out_lane, e_cur.lane);
          check("model_sum", out_sum, e_cur.sum);
          check("model_ovf", out_ovf, e_cur.ovf);
        end
      end
      stalled   = out_valid && !out_ready;
      hold_sum  = out_sum;
      hold_lane = out_lane;
      hold_ovf  = out_ovf;
      if (in_valid && in_ready) begin
        m_a = model_acc[in_lane];
        m_d = $signed(in_data);
        if (in_clear) begin
          m_s = m_d;
          model_ovf[in_lane] = 0;
        end else begin
          m_s = m_a + m_d;
          if (m_s > MAX_POS || m_s < MIN_NEG) model_ovf[in_lane] = 1;
          m_wrap = m_s[31:0];
          m_s = m_wrap;
        end
        model_acc[in_lane] = m_s;
        e_cur.lane = in_lane;
        e_cur.sum  = m_s[31:0];
        e_cur.ovf  = model_ovf[in_lane];
        exp_q.push_back(e_cur);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called 1 unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic send(input int lane, input logic clr, input logic [31:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_lane  = lane_t'(lane);
    in_clear = clr;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_accept_timeout", 0, 1);
  endtask

  // Single isolated beat with a literal expected result; lat counts falling
  // edges from the accepting edge until out_valid is seen.
  task automatic txn(input string name, input int lane, input logic clr,
                     input logic [31:0] d, input logic [31:0] es, input logic eo,
                     output int lat);
    send(lane, clr, d);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_lane"}, out_lane, lane_t'(lane));
    check({name, "_sum"}, out_sum, es);
    check({name, "_ovf"}, out_ovf, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int w;
    logic [31:0] v;

    rst = 1'b1;
    in_valid = 1'b0;
    in_lane = '0;
    in_clear = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_lane", out_lane, 0);
    check("reset_out_ovf", out_ovf, 0);
    check("reset_released_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1: lane 0 add 5 then 7; out_valid two edges after the beat is presented.
    txn("t1_add5", 0, 1'b0, 32'd5, 32'd5, 1'b0, lat);
    check("t1_latency5", lat, 2);
    txn("t1_add7", 0, 1'b0, 32'd7, 32'd12, 1'b0, lat);
    check("t1_latency7", lat, 2);

    // 2: positive overflow sets the sticky flag, clear drops it.
    txn("t2_clr_max", 1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, lat);
    txn("t2_add1", 1, 1'b0, 32'd1, 32'h8000_0000, 1'b1, lat);
    txn("t2_add_neg", 1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, lat);
    txn("t2_clr3", 1, 1'b1, 32'd3, 32'd3, 1'b0, lat);

    // 3: four back-to-back adds to lane 2.
    fork
      begin
        for (int i = 0; i < 4; i++) send(2, 1'b0, 32'd1);
        in_valid = 1'b0;
      end
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 10);
        for (int i = 1; i <= 4; i++) begin
          check("t3_b2b_valid", out_valid, 1'b1);
          check("t3_b2b_sum", out_sum, i);
          if (i < 4) @(negedge clk);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Carry propagation across every group boundary, plus -1 + 1 wrap.
    for (int g = 0; g < NGROUPS; g++) begin
      v = (32'd1 << (g * CLA_GROUP)) - 32'd1;
      txn("carry_clr", 0, 1'b1, v, v, 1'b0, lat);
      txn("carry_add", 0, 1'b0, 32'd1, v + 32'd1, 1'b0, lat);
    end
    txn("wrap_clr", 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    txn("wrap_add", 0, 1'b0, 32'd1, 32'd0, 1'b0, lat);
    txn("negovf_clr", 0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    txn("negovf_add", 0, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, lat);

    // 4: stall with in_valid held high.
    out_ready = 1'b0;
    fork
      begin
        send(3, 1'b0, 32'd10);
        send(3, 1'b0, 32'd20);
        send(3, 1'b0, 32'd30);
        send(3, 1'b0, 32'd40);
        in_valid = 1'b0;
      end
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 10);
        repeat (3) @(negedge clk);
        check("t4_stall_in_ready", in_ready, 1'b0);
        check("t4_stall_out_valid", out_valid, 1'b1);
        check("t4_stall_first_sum", out_sum, 32'd10);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    txn("t4_total", 3, 1'b0, 32'd0, 32'd100, 1'b0, lat);

    // 5: reset with two beats in flight (one in S1, one stalled at the output).
    out_ready = 1'b0;
    send(0, 1'b0, 32'd100);
    send(0, 1'b0, 32'd200);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("t5_flushed_valid", out_valid, 1'b0);
    @(negedge clk);
    check("t5_no_late_output", out_valid, 1'b0);
    @(posedge clk);
    #1;
    txn("t5_add9", 0, 1'b0, 32'd9, 32'd9, 1'b0, lat);

    // 6: interleaved lanes back to back, then read each lane by adding 0.
    send(0, 1'b0, 32'd1);
    send(1, 1'b0, 32'd2);
    send(2, 1'b0, 32'd3);
    send(3, 1'b0, 32'd4);
    send(0, 1'b0, 32'd10);
    send(1, 1'b0, 32'hFFFF_FFFB);
    send(2, 1'b0, 32'h7FFF_FFFF);
    send(3, 1'b1, 32'd42);
    send(0, 1'b0, 32'd0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    txn("t6_lane0", 0, 1'b0, 32'd0, 32'd20, 1'b0, lat);
    txn("t6_lane1", 1, 1'b0, 32'd0, 32'hFFFF_FFFD, 1'b0, lat);
    txn("t6_lane2", 2, 1'b0, 32'd0, 32'h8000_0002, 1'b1, lat);
    txn("t6_lane3", 3, 1'b0, 32'd0, 32'd42, 1'b0, lat);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
